// File: rtl/coreport2.sv
// rtl/coreport2.sv - second-generation Wishbone GPIO port with debounce and interrupts
//
// Ports:
//   wb_clk, wb_rst_n          clock, asynchronous active-low reset
//   wb_adr_i/dat_i/we_i/cyc_i/stb_i   Wishbone slave request (only adr[7:0] decoded)
//   wb_dat_o, wb_ack_o        registered read data and single-cycle ack
//   wb_err_o, wb_rty_o        always 0
//   gpio_i                    asynchronous pad inputs
//   gpio_o, gpio_oe           output latch and output enable (DDR)
//   irq                       level-high interrupt, |(IFR & IMR)
module coreport2 #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] INITIAL_DDR   = '0,
    parameter logic [WIDTH-1:0] INITIAL_DATAR = '0,
    parameter int               SYNC_STAGES   = 2,
    parameter int               DB_WIDTH      = 16
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic [31:0]      wb_adr_i,
    input  logic [WIDTH-1:0] wb_dat_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [WIDTH-1:0] wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_rty_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [7:0] ADR_DATAR = 8'h00;
    localparam logic [7:0] ADR_DDR   = 8'h04;
    localparam logic [7:0] ADR_IMR   = 8'h08;
    localparam logic [7:0] ADR_IFR   = 8'h0C;
    localparam logic [7:0] ADR_IER   = 8'h10;
    localparam logic [7:0] ADR_DIR   = 8'h14;
    localparam logic [7:0] ADR_IPR   = 8'h18;
    localparam logic [7:0] ADR_SET   = 8'h1C;
    localparam logic [7:0] ADR_CLR   = 8'h20;
    localparam logic [7:0] ADR_TGL   = 8'h24;
    localparam logic [7:0] ADR_OUTR  = 8'h28;
    localparam logic [7:0] ADR_DBR   = 8'h2C;

    // Register state
    logic [WIDTH-1:0]    latch_q, latch_d;
    logic [WIDTH-1:0]    ddr_q;
    logic [WIDTH-1:0]    imr_q;
    logic [WIDTH-1:0]    ifr_q, ifr_d;
    logic [WIDTH-1:0]    ier_q;
    logic [WIDTH-1:0]    dir_q;
    logic [WIDTH-1:0]    ipr_q;
    logic [DB_WIDTH-1:0] dbr_q;
    logic [DB_WIDTH-1:0] presc_q;

    // Input path state
    logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]    hist0_q;   // most recent tick sample
    logic [WIDTH-1:0]    hist1_q;   // sample one tick older
    logic [WIDTH-1:0]    deb_q;
    logic [WIDTH-1:0]    p_prev_q;

    // Bus state
    logic                ack_q;
    logic [WIDTH-1:0]    dat_q;

    // Combinational helpers
    logic [7:0]          adr;
    logic                req, wr, rd;
    logic [WIDTH-1:0]    sync_in;
    logic                db_bypass;
    logic                tick;
    logic [WIDTH-1:0]    agree;
    logic [WIDTH-1:0]    debounced_in;
    logic [WIDTH-1:0]    p;
    logic [WIDTH-1:0]    eligible;
    logic [WIDTH-1:0]    set_irq;
    logic [WIDTH-1:0]    clr_irq;
    logic [WIDTH-1:0]    rdata;
    logic [DB_WIDTH-1:0] dbr_wdata;
    logic [WIDTH-1:0]    dbr_rdata;
    logic                unused_adr;

    assign adr        = wb_adr_i[7:0];
    assign unused_adr = ^wb_adr_i[31:8];

    // Ack low gates the request so a held strobe is serviced every other cycle.
    assign req = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr  = req & wb_we_i;
    assign rd  = req & ~wb_we_i;

    assign dbr_wdata = DB_WIDTH'(wb_dat_i);
    assign dbr_rdata = WIDTH'(dbr_q);

    assign sync_in   = sync_q[SYNC_STAGES-1];
    assign db_bypass = (dbr_q == '0);
    assign tick      = ~db_bypass & (presc_q == dbr_q);

    // The new sample plus the two held samples form the 3-sample window.
    assign agree        = ~(sync_in ^ hist0_q) & ~(sync_in ^ hist1_q);
    assign debounced_in = db_bypass ? sync_in : deb_q;

    // Per-pin interrupt qualification. Edge mode additionally requires the
    // polarity-adjusted input to have been low on the previous cycle.
    assign p        = debounced_in ^ ipr_q;
    assign eligible = imr_q & ~ddr_q;
    assign set_irq  = eligible & p & ~(ier_q & p_prev_q);
    assign clr_irq  = (wr && adr == ADR_IFR) ? wb_dat_i : '0;
    assign ifr_d    = set_irq | (ifr_q & ~clr_irq);

    always_comb begin
        latch_d = latch_q;
        if (wr) begin
            case (adr)
                ADR_DATAR: latch_d = wb_dat_i ^ dir_q;
                ADR_SET:   latch_d = latch_q | wb_dat_i;
                ADR_CLR:   latch_d = latch_q & ~wb_dat_i;
                ADR_TGL:   latch_d = latch_q ^ wb_dat_i;
                default:   latch_d = latch_q;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (adr)
            ADR_DATAR: rdata = debounced_in ^ dir_q;
            ADR_DDR:   rdata = ddr_q;
            ADR_IMR:   rdata = imr_q;
            ADR_IFR:   rdata = ifr_q;
            ADR_IER:   rdata = ier_q;
            ADR_DIR:   rdata = dir_q;
            ADR_IPR:   rdata = ipr_q;
            ADR_OUTR:  rdata = latch_q;
            ADR_DBR:   rdata = dbr_rdata;
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            latch_q  <= INITIAL_DATAR;
            ddr_q    <= INITIAL_DDR;
            imr_q    <= '0;
            ifr_q    <= '0;
            ier_q    <= '0;
            dir_q    <= '0;
            ipr_q    <= '0;
            dbr_q    <= '0;
            presc_q  <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist0_q  <= '0;
            hist1_q  <= '0;
            deb_q    <= '0;
            p_prev_q <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            // Bus handshake and read data capture
            ack_q <= req;
            if (rd) begin
                dat_q <= rdata;
            end

            // Register writes
            latch_q <= latch_d;
            ifr_q   <= ifr_d;
            if (wr) begin
                case (adr)
                    ADR_DDR: ddr_q <= wb_dat_i;
                    ADR_IMR: imr_q <= wb_dat_i;
                    ADR_IER: ier_q <= wb_dat_i;
                    ADR_DIR: dir_q <= wb_dat_i;
                    ADR_IPR: ipr_q <= wb_dat_i;
                    ADR_DBR: dbr_q <= dbr_wdata;
                    default: ;
                endcase
            end

            // Input synchroniser
            sync_q[0] <= gpio_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end

            // Shared prescaler; a DBR write restarts the period.
            if ((wr && adr == ADR_DBR) || db_bypass || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            // In bypass the history tracks the input so that enabling the
            // debouncer later starts from a consistent state.
            if (db_bypass) begin
                hist0_q <= sync_in;
                hist1_q <= sync_in;
                deb_q   <= sync_in;
            end else if (tick) begin
                hist0_q <= sync_in;
                hist1_q <= hist0_q;
                deb_q   <= (deb_q & ~agree) | (sync_in & agree);
            end

            p_prev_q <= p;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign gpio_o   = latch_q;
    assign gpio_oe  = ddr_q;
    assign irq      = |(ifr_q & imr_q);

endmodule

// File: tb/tb_coreport2.sv
// tb/tb_coreport2.sv - directed scoreboard bench for coreport2
module tb_coreport2;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic [31:0] wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [7:0]  wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [7:0]  gpio_i;
    logic [7:0]  gpio_o;
    logic [7:0]  gpio_oe;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] sb_q [$];

    coreport2 #(
        .WIDTH         (8),
        .INITIAL_DDR   (8'h0F),
        .INITIAL_DATAR (8'h05),
        .SYNC_STAGES   (2),
        .DB_WIDTH      (16)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One Wishbone access; reads pop their expected value from the scoreboard.
    task automatic bus(input logic [7:0] adr, input logic we, input logic [7:0] dat, input string tag);
        int lat;
        logic [7:0] exp_v;
        @(posedge wb_clk); #1;
        wb_adr_i = {24'h0, adr};
        wb_we_i  = we;
        wb_dat_i = dat;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        lat = 0;
        do begin
            @(posedge wb_clk); #1;
            lat++;
        end while (!wb_ack_o && lat < 8);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'd1);
        if (!we) begin
            exp_v = sb_q.pop_front();
            check(tag, 32'(wb_dat_o), 32'(exp_v));
        end
    endtask

    task automatic wr(input logic [7:0] adr, input logic [7:0] dat);
        bus(adr, 1'b1, dat, "wr");
    endtask

    task automatic rd(input logic [7:0] adr, input logic [7:0] exp_v, input string tag);
        sb_q.push_back(exp_v);
        bus(adr, 1'b0, 8'h00, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wb_rst_n = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        gpio_i   = '0;

        // Reset state
        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_oe",   32'(gpio_oe),  32'h0F);
        check("rst_out",  32'(gpio_o),   32'h05);
        check("rst_irq",  32'(irq),      32'h0);
        check("rst_ack",  32'(wb_ack_o), 32'h0);
        check("rst_dat",  32'(wb_dat_o), 32'h0);
        check("rst_err",  32'(wb_err_o), 32'h0);
        check("rst_rty",  32'(wb_rty_o), 32'h0);
        wb_rst_n = 1'b1;
        rd(8'h04, 8'h0F, "rd_ddr_rst");

        // Output latch: DATAR, SET, CLR, TGL, DIR inversion
        wr(8'h00, 8'hA5); rd(8'h28, 8'hA5, "outr_datar");
        wr(8'h1C, 8'h0A); rd(8'h28, 8'hAF, "outr_set");
        wr(8'h20, 8'h80); rd(8'h28, 8'h2F, "outr_clr");
        wr(8'h24, 8'h01); rd(8'h28, 8'h2E, "outr_tgl");
        check("gpio_o_2e", 32'(gpio_o), 32'h2E);
        rd(8'h1C, 8'h00, "rd_set_zero");
        wr(8'h14, 8'hFF);
        wr(8'h00, 8'h00); rd(8'h28, 8'hFF, "outr_dir");
        rd(8'h00, 8'hFF, "datar_dir");
        wr(8'h28, 8'h00); rd(8'h28, 8'hFF, "outr_ro");
        wr(8'h14, 8'h00);

        // Edge interrupt latency on pin 0, then W1C
        wr(8'h04, 8'h00);
        wr(8'h10, 8'h01);
        wr(8'h18, 8'h00);
        wr(8'h08, 8'h01);
        gpio_i[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge wb_clk); #1;
            check($sformatf("edge_irq_c%0d", i), 32'(irq), (i == 3) ? 32'h1 : 32'h0);
        end
        rd(8'h0C, 8'h01, "ifr_edge");
        wr(8'h0C, 8'h01);
        check("irq_w1c", 32'(irq), 32'h0);
        repeat (3) @(posedge wb_clk);
        #1;
        check("irq_held_high", 32'(irq), 32'h0);

        // Level mode, low polarity on pin 2: a W1C loses to a persisting level
        wr(8'h08, 8'h00);
        wr(8'h10, 8'h00);
        wr(8'h18, 8'h04);
        wr(8'h08, 8'h04);
        rd(8'h0C, 8'h04, "ifr_level");
        check("irq_level", 32'(irq), 32'h1);
        wr(8'h0C, 8'h04);
        check("irq_level_reassert", 32'(irq), 32'h1);
        rd(8'h0C, 8'h04, "ifr_level_reassert");

        // Edge mode falling on pin 2: set coincides with W1C
        wr(8'h10, 8'h04);
        gpio_i[2] = 1'b1;
        repeat (5) @(posedge wb_clk);
        wr(8'h0C, 8'h04);
        rd(8'h0C, 8'h00, "ifr_cleared");
        check("irq_cleared", 32'(irq), 32'h0);
        gpio_i[2] = 1'b0;
        @(posedge wb_clk);
        wr(8'h0C, 8'h04);
        rd(8'h0C, 8'h04, "ifr_set_wins");

        // Flag retained when masked
        wr(8'h08, 8'h00);
        rd(8'h0C, 8'h04, "ifr_retained");
        check("irq_masked", 32'(irq), 32'h0);
        wr(8'h0C, 8'h04);
        rd(8'h0C, 8'h00, "ifr_final_clr");

        // Debounce with DBR=3
        wr(8'h2C, 8'h03);
        rd(8'h2C, 8'h03, "rd_dbr");
        rd(8'h00, 8'h01, "datar_pre_glitch");
        gpio_i[1] = 1'b1;
        repeat (5) @(posedge wb_clk);
        gpio_i[1] = 1'b0;
        repeat (20) @(posedge wb_clk);
        rd(8'h00, 8'h01, "datar_glitch");
        gpio_i[1] = 1'b1;
        repeat (20) @(posedge wb_clk);
        rd(8'h00, 8'h03, "datar_stable");

        // Unmapped offset
        rd(8'h30, 8'h00, "rd_unmapped");

        // Held strobe: ack 0,1,0,1
        @(posedge wb_clk); #1;
        wb_adr_i = 32'h04; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        check("hold_c0", 32'(wb_ack_o), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge wb_clk); #1;
            check($sformatf("hold_c%0d", i), 32'(wb_ack_o), 32'(i % 2));
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge wb_clk); #1;
        check("hold_end", 32'(wb_ack_o), 32'h0);

        // Reset during an ack cycle
        wr(8'h04, 8'hAA);
        wr(8'h08, 8'h0F);
        @(posedge wb_clk); #1;
        wb_adr_i = 32'h04; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge wb_clk); #1;
        check("pre_rst_ack", 32'(wb_ack_o), 32'h1);
        check("pre_rst_dat", 32'(wb_dat_o), 32'hAA);
        wb_rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 32'(wb_ack_o), 32'h0);
        check("mid_rst_oe",  32'(gpio_oe),  32'h0F);
        check("mid_rst_out", 32'(gpio_o),   32'h05);
        check("mid_rst_dat", 32'(wb_dat_o), 32'h00);
        check("mid_rst_irq", 32'(irq),      32'h0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        #3;
        wb_rst_n = 1'b1;
        rd(8'h04, 8'h0F, "post_rst_ddr");
        rd(8'h08, 8'h00, "post_rst_imr");
        rd(8'h2C, 8'h00, "post_rst_dbr");
        rd(8'h28, 8'h05, "post_rst_outr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
